// File: rtl/bs_pkg.sv
// Shared constants and parameter defaults for the bitstream output FIFO.
package bs_pkg;
  localparam int         DEPTH_LOG2_DEF = 8;
  localparam int         SH_BYTES_DEF   = 3;
  localparam int         CV_BYTES_DEF   = 10;
  localparam bit         EPB_EN_DEF     = 1'b1;

  // Emulation-prevention byte and the zero-run counter that triggers it.
  localparam logic [7:0] EPB_BYTE = 8'h03;
  localparam int         ZR_W     = 2;
  localparam logic [ZR_W-1:0] ZR_MAX = ZR_W'(2);
endpackage

// File: rtl/bs_epb.sv
// Output stage: one-byte valid/ready register with emulation-prevention
// byte insertion after two emitted zero bytes.
module bs_epb
  import bs_pkg::*;
#(
  parameter bit EPB_EN = EPB_EN_DEF
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       nal_start,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_byte,
  output logic       pop,
  output logic       bs_valid,
  output logic [7:0] bs_o,
  input  logic       bs_ready
);

  logic            load;
  logic            ins;
  logic [ZR_W-1:0] zr;

  // Register may take a new byte when empty or when the current one leaves.
  assign load = !bs_valid || bs_ready;
  // Insert 0x03 ahead of a small byte after two zeros; the FIFO byte waits.
  assign ins  = (zr == ZR_MAX) && (fifo_byte <= EPB_BYTE);
  assign pop  = load && !fifo_empty && !ins;

  // Output register: holds stable while stalled, reloads otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bs_valid <= 1'b0;
      bs_o     <= 8'h00;
    end else if (load) begin
      bs_valid <= !fifo_empty;
      if (!fifo_empty) bs_o <= ins ? EPB_BYTE : fifo_byte;
    end
  end

  generate
    if (EPB_EN) begin : g_zr
      // Zero-run over emitted bytes; nal_start wins over any update.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                        zr <= '0;
        else if (nal_start)             zr <= '0;
        else if (load && !fifo_empty) begin
          if (ins)                      zr <= '0;
          else if (fifo_byte == 8'h00)  zr <= (zr == ZR_MAX) ? ZR_MAX : zr + 1'b1;
          else                          zr <= '0;
        end
      end
    end else begin : g_nozr
      assign zr = '0;
    end
  endgenerate

endmodule

// File: rtl/bs_fifo.sv
// Bitstream byte FIFO: multi-byte header/CAVLC/trailing writes with
// all-or-nothing acceptance, single-byte output through bs_epb.
module bs_fifo
  import bs_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int SH_BYTES   = SH_BYTES_DEF,
  parameter int CV_BYTES   = CV_BYTES_DEF,
  parameter bit EPB_EN     = EPB_EN_DEF
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sh_we,
  input  logic [$clog2(SH_BYTES+1)-1:0] sh_inc,
  input  logic [8*SH_BYTES-1:0]         sh_bit,
  input  logic                          cv_we,
  input  logic [$clog2(CV_BYTES+1)-1:0] cv_inc,
  input  logic [8*CV_BYTES-1:0]         cv_bit,
  input  logic                          frame_done,
  input  logic [7:0]                    rbsp_trailing,
  input  logic                          nal_start,
  output logic                          bs_valid,
  output logic [7:0]                    bs_o,
  input  logic                          bs_ready,
  output logic                          bs_empty_o,
  output logic                          afull_o,
  output logic [DEPTH_LOG2:0]           level_o,
  output logic                          ovf_err_o,
  output logic                          col_err_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int SIW   = $clog2(SH_BYTES + 1);
  localparam int CIW   = $clog2(CV_BYTES + 1);
  localparam int WB    = (CV_BYTES > SH_BYTES) ? CV_BYTES : SH_BYTES;
  localparam int CW    = $clog2(WB + 1);

  logic [7:0]          mem [DEPTH];
  logic [PW-1:0]       wptr, rptr, level, free;
  logic                fd_q, tr_req, fifo_empty, pop;
  logic                w_req, w_bad, w_ok, w_ovf, w_col;
  logic [CW-1:0]       w_cnt;
  logic [WB-1:0][7:0]  w_byte;

  // Pointers carry a wrap bit, so plain subtraction gives occupancy 0..DEPTH.
  assign level      = wptr - rptr;
  assign free       = PW'(DEPTH) - level;
  assign fifo_empty = (wptr == rptr);
  assign level_o    = level;
  assign afull_o    = free < PW'(CV_BYTES);
  assign bs_empty_o = fifo_empty && !bs_valid && !frame_done;

  // Trailing byte only on the first cycle frame_done is seen high.
  assign tr_req = frame_done && !fd_q && (rbsp_trailing != 8'h00);

  // Pick the winning writer; byte 0 is the first byte stored.
  always_comb begin
    w_req  = 1'b0;
    w_bad  = 1'b0;
    w_cnt  = '0;
    w_byte = '0;
    if (sh_we) begin
      w_req = 1'b1;
      w_cnt = CW'(sh_inc);
      w_bad = sh_inc > SIW'(SH_BYTES);
      for (int i = 0; i < SH_BYTES; i++) w_byte[i] = sh_bit[8*(SH_BYTES-1-i) +: 8];
    end else if (cv_we) begin
      w_req = 1'b1;
      w_cnt = CW'(cv_inc);
      w_bad = cv_inc > CIW'(CV_BYTES);
      for (int i = 0; i < CV_BYTES; i++) w_byte[i] = cv_bit[8*(CV_BYTES-1-i) +: 8];
    end else if (tr_req) begin
      w_req     = 1'b1;
      w_cnt     = CW'(1);
      w_byte[0] = rbsp_trailing;
    end
  end

  // A write lands whole or not at all; oversize or no-room writes are errors.
  assign w_ok  = w_req && !w_bad && (w_cnt != '0) && (PW'(w_cnt) <= free);
  assign w_ovf = w_req && (w_bad || (PW'(w_cnt) > free));
  assign w_col = (sh_we && (cv_we || tr_req)) || (cv_we && tr_req);

  // Storage: unreset, consecutive bytes from the write pointer, wrapping.
  always_ff @(posedge clk) begin
    if (w_ok)
      for (int i = 0; i < WB; i++)
        if (CW'(i) < w_cnt) mem[wptr[DEPTH_LOG2-1:0] + DEPTH_LOG2'(i)] <= w_byte[i];
  end

  // Pointers and frame_done edge history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      fd_q <= 1'b0;
    end else begin
      fd_q <= frame_done;
      if (w_ok) wptr <= wptr + PW'(w_cnt);
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err_o <= 1'b0;
      col_err_o <= 1'b0;
    end else begin
      if (w_ovf) ovf_err_o <= 1'b1;
      if (w_col) col_err_o <= 1'b1;
    end
  end

  bs_epb #(.EPB_EN(EPB_EN)) u_epb (
    .clk        (clk),
    .rst        (rst),
    .nal_start  (nal_start),
    .fifo_empty (fifo_empty),
    .fifo_byte  (mem[rptr[DEPTH_LOG2-1:0]]),
    .pop        (pop),
    .bs_valid   (bs_valid),
    .bs_o       (bs_o),
    .bs_ready   (bs_ready)
  );

endmodule

// File: tb/tb_bs_fifo.sv
// Directed + randomized bench for bs_fifo; output stream is compared with
// a byte-stream model that applies emulation prevention to accepted writes.
module tb_bs_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sh_we = 1'b0;
  logic [1:0]  sh_inc = '0;
  logic [23:0] sh_bit = '0;
  logic        cv_we = 1'b0;
  logic [3:0]  cv_inc = '0;
  logic [79:0] cv_bit = '0;
  logic        frame_done = 1'b0;
  logic [7:0]  rbsp_trailing = '0;
  logic        nal_start = 1'b0;
  logic        bs_valid;
  logic [7:0]  bs_o;
  logic        bs_ready = 1'b0;
  logic        bs_empty_o, afull_o, ovf_err_o, col_err_o;
  logic [8:0]  level_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] expq[$];
  logic [7:0] got[$];
  int         mzr = 0;

  bs_fifo dut (
    .clk(clk), .rst(rst),
    .sh_we(sh_we), .sh_inc(sh_inc), .sh_bit(sh_bit),
    .cv_we(cv_we), .cv_inc(cv_inc), .cv_bit(cv_bit),
    .frame_done(frame_done), .rbsp_trailing(rbsp_trailing), .nal_start(nal_start),
    .bs_valid(bs_valid), .bs_o(bs_o), .bs_ready(bs_ready),
    .bs_empty_o(bs_empty_o), .afull_o(afull_o), .level_o(level_o),
    .ovf_err_o(ovf_err_o), .col_err_o(col_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Stream rule: after two zeros, a byte <= 3 is preceded by 0x03.
  task automatic mpush(input logic [7:0] b);
    if (mzr == 2 && b <= 8'h03) begin
      expq.push_back(8'h03);
      mzr = 0;
    end
    expq.push_back(b);
    mzr = (b == 8'h00) ? ((mzr == 2) ? 2 : mzr + 1) : 0;
  endtask

  // One clock; a byte handed over at this edge is checked first.
  task automatic cyc();
    if (bs_valid && bs_ready) begin
      if (expq.size() == 0) chk("out_extra", 32'(bs_o), 32'h1ff);
      else chk("out_byte", 32'(bs_o), 32'(expq.pop_front()));
      got.push_back(bs_o);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input bit is_sh, input int inc, input logic [79:0] d, input bit ok);
    if (is_sh) begin sh_we = 1'b1; sh_inc = inc[1:0]; sh_bit = d[79 -: 24]; end
    else       begin cv_we = 1'b1; cv_inc = inc[3:0]; cv_bit = d; end
    if (ok) for (int i = 0; i < inc; i++) mpush(d[79 - 8*i -: 8]);
    cyc();
    sh_we = 1'b0;
    cv_we = 1'b0;
  endtask

  task automatic drain();
    bs_ready = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      if (expq.size() == 0 && !bs_valid) break;
      cyc();
    end
    chk("drain_done", 32'(expq.size() == 0 && !bs_valid), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sh_we = 1'b0; cv_we = 1'b0; frame_done = 1'b0; nal_start = 1'b0;
    rbsp_trailing = '0; bs_ready = 1'b0;
    #1;
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_valid", 32'(bs_valid), 32'd0);
    chk("rst_bs_o", 32'(bs_o), 32'h00);
    chk("rst_ovf", 32'(ovf_err_o), 32'd0);
    chk("rst_col", 32'(col_err_o), 32'd0);
    chk("rst_empty", 32'(bs_empty_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    expq.delete();
    mzr = 0;
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 5))
      0, 1:    return 8'h00;
      2:       return 8'h01;
      3:       return 8'h03;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    logic [79:0] d;
    @(negedge clk);
    do_reset();
    chk("afull_empty", 32'(afull_o), 32'd0);

    // Header write AA BB CC: one-cycle latency, consecutive output.
    bs_ready = 1'b1;
    got.delete();
    wr(1'b1, 3, {24'hAABBCC, 56'h0}, 1'b1);
    chk("e0_valid", 32'(bs_valid), 32'd0);
    chk("e0_level", 32'(level_o), 32'd3);
    cyc();
    chk("e1_valid", 32'(bs_valid), 32'd1);
    chk("e1_byte", 32'(bs_o), 32'hAA);
    cyc();
    chk("e2_byte", 32'(bs_o), 32'hBB);
    cyc();
    chk("e3_byte", 32'(bs_o), 32'hCC);
    cyc();
    chk("hdr_level", 32'(level_o), 32'd0);
    chk("hdr_valid", 32'(bs_valid), 32'd0);

    // Emulation prevention, then the same bytes split by nal_start.
    got.delete();
    wr(1'b0, 3, {24'h000001, 56'h0}, 1'b1);
    drain();
    chk("epb_cnt", 32'(got.size()), 32'd4);
    if (got.size() == 4) begin
      chk("epb_b0", 32'(got[0]), 32'h00);
      chk("epb_b1", 32'(got[1]), 32'h00);
      chk("epb_b2", 32'(got[2]), 32'h03);
      chk("epb_b3", 32'(got[3]), 32'h01);
    end
    got.delete();
    wr(1'b1, 1, 80'h0, 1'b1);
    drain();
    nal_start = 1'b1;
    mzr = 0;
    cyc();
    nal_start = 1'b0;
    wr(1'b0, 2, {16'h0001, 64'h0}, 1'b1);
    drain();
    chk("nal_cnt", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("nal_b0", 32'(got[0]), 32'h00);
      chk("nal_b1", 32'(got[1]), 32'h00);
      chk("nal_b2", 32'(got[2]), 32'h01);
    end

    // inc = 0 is a no-op; inc above CV_BYTES is dropped with ovf.
    wr(1'b1, 0, 80'hFF, 1'b0);
    chk("inc0_level", 32'(level_o), 32'd0);
    chk("inc0_ovf", 32'(ovf_err_o), 32'd0);
    wr(1'b0, 12, {80{1'b1}}, 1'b0);
    chk("big_level", 32'(level_o), 32'd0);
    chk("big_ovf", 32'(ovf_err_o), 32'd1);
    chk("big_col", 32'(col_err_o), 32'd0);

    // Header and CAVLC collide: header wins.
    bs_ready = 1'b0;
    sh_we = 1'b1; sh_inc = 2'd2; sh_bit = 24'h123456;
    cv_we = 1'b1; cv_inc = 4'd3; cv_bit = 80'hDEADBEEF;
    mpush(8'h12);
    mpush(8'h34);
    cyc();
    sh_we = 1'b0; cv_we = 1'b0;
    chk("col_level", 32'(level_o), 32'd2);
    chk("col_flag", 32'(col_err_o), 32'd1);
    drain();

    // frame_done held high writes exactly one trailing byte.
    bs_ready = 1'b0;
    frame_done = 1'b1; rbsp_trailing = 8'h80;
    mpush(8'h80);
    cyc();
    chk("tr_level1", 32'(level_o), 32'd1);
    for (int k = 0; k < 3; k++) cyc();
    chk("tr_level0", 32'(level_o), 32'd0);
    chk("tr_byte", 32'(bs_o), 32'h80);
    drain();
    chk("tr_empty_fd", 32'(bs_empty_o), 32'd0);
    frame_done = 1'b0;
    #1;
    chk("tr_empty", 32'(bs_empty_o), 32'd1);

    // Reset while data is buffered discards it and clears the flags.
    bs_ready = 1'b0;
    wr(1'b0, 5, {40'h0102030405, 40'h0}, 1'b1);
    cyc();
    do_reset();

    // Advance the write pointer to 250, then a wrapping 10-byte write.
    bs_ready = 1'b1;
    for (int w = 0; w < 25; w++) begin
      for (int i = 0; i < 10; i++) d[79 - 8*i -: 8] = pick();
      wr(1'b0, 10, d, 1'b1);
      drain();
    end
    d = 80'h112233445566778899AA;
    got.delete();
    bs_ready = 1'b0;
    wr(1'b0, 10, d, 1'b1);
    chk("wrap_level", 32'(level_o), 32'd10);
    cyc();
    chk("wrap_level9", 32'(level_o), 32'd9);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("stall_valid", 32'(bs_valid), 32'd1);
      chk("stall_byte", 32'(bs_o), 32'h11);
    end
    drain();
    chk("wrap_cnt", 32'(got.size()), 32'd10);
    if (got.size() == 10)
      for (int i = 0; i < 10; i++) chk("wrap_byte", 32'(got[i]), 32'(d[79 - 8*i -: 8]));

    // Fill to 250, overflow drop, then fill to full.
    do_reset();
    for (int w = 0; w < 25; w++) begin
      for (int i = 0; i < 10; i++) d[79 - 8*i -: 8] = 8'($urandom_range(4, 255));
      wr(1'b0, 10, d, 1'b1);
      if (w == 23) chk("afull_239", 32'(afull_o), 32'd0);
    end
    chk("fill_249", 32'(level_o), 32'd249);
    chk("afull_249", 32'(afull_o), 32'd1);
    wr(1'b1, 1, {8'h55, 72'h0}, 1'b1);
    chk("fill_250", 32'(level_o), 32'd250);
    chk("ovf_pre", 32'(ovf_err_o), 32'd0);
    wr(1'b0, 10, {80{1'b1}}, 1'b0);
    chk("ovf_flag", 32'(ovf_err_o), 32'd1);
    chk("ovf_level", 32'(level_o), 32'd250);
    wr(1'b1, 3, {24'h606162, 56'h0}, 1'b1);
    wr(1'b1, 3, {24'h636465, 56'h0}, 1'b1);
    chk("full_level", 32'(level_o), 32'd256);
    wr(1'b1, 1, {8'h77, 72'h0}, 1'b0);
    chk("full_drop", 32'(level_o), 32'd256);
    drain();
    chk("full_drained", 32'(level_o), 32'd0);

    // Randomized traffic with random back-pressure.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      bit is_sh;
      int inc;
      bs_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        is_sh = 1'($urandom_range(0, 1));
        inc = is_sh ? $urandom_range(0, 3) : $urandom_range(0, 10);
        for (int i = 0; i < 10; i++) d[79 - 8*i -: 8] = pick();
        if (expq.size() + 2 * inc < 200) wr(is_sh, inc, d, 1'b1);
        else cyc();
      end else begin
        cyc();
      end
    end
    drain();
    chk("rnd_level", 32'(level_o), 32'd0);
    chk("rnd_empty", 32'(bs_empty_o), 32'd1);
    chk("rnd_ovf", 32'(ovf_err_o), 32'd0);
    chk("rnd_col", 32'(col_err_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
